// File: rtl/mips_pkg.sv
// Shared MIPS constants: datapath widths and architectural register indices.
package mips_pkg;

   localparam int          DATA_W   = 32;
   localparam int          ADDR_W   = 5;
   localparam logic [4:0]  REG_ZERO = 5'd0;
   localparam logic [4:0]  REG_SP   = 5'd29;
   localparam logic [4:0]  REG_RA   = 5'd31;
   localparam logic [31:0] SP_INIT  = 32'h0000_03FC;

endpackage

// File: rtl/wb_select.sv
// Write-back destination/data selection: jal link write takes priority over a
// normal register write, and any write aimed at $0 is suppressed.
module wb_select #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic              regWrite_in,
   input  logic              regWrite_jal_in,
   input  logic [ADDR_W-1:0] RegDst_in,
   input  logic [DATA_W-1:0] RegData_in,
   input  logic [DATA_W-1:0] PCPlusFour_in,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata
);
   import mips_pkg::*;

   logic raw_we;

   always_comb begin
      raw_we = 1'b0;
      waddr  = RegDst_in;
      wdata  = RegData_in;
      if (regWrite_jal_in) begin
         raw_we = 1'b1;
         waddr  = ADDR_W'(REG_RA);
         wdata  = PCPlusFour_in;
      end else if (regWrite_in) begin
         raw_we = 1'b1;
      end
   end

   assign we = raw_we && (waddr != ADDR_W'(REG_ZERO));

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back register file: 32x32 array, two combinational read ports and a
// committed-write counter. Define WB_BYPASS_EN for same-cycle write-through reads.
module wb_regfile #(
   parameter int                DATA_W  = mips_pkg::DATA_W,
   parameter int                ADDR_W  = mips_pkg::ADDR_W,
   parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(mips_pkg::SP_INIT)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              regWrite_in,
   input  logic              regWrite_jal_in,
   input  logic [ADDR_W-1:0] RegDst_in,
   input  logic [DATA_W-1:0] RegData_in,
   input  logic [DATA_W-1:0] PCPlusFour_in,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic [31:0]       WriteCount
);
   import mips_pkg::*;

   localparam int NREGS = 2 ** ADDR_W;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] regs [NREGS];
   logic [31:0]       write_count;
   logic              byp1;
   logic              byp2;

   wb_select #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_wb_select (
      .regWrite_in     (regWrite_in),
      .regWrite_jal_in (regWrite_jal_in),
      .RegDst_in       (RegDst_in),
      .RegData_in      (RegData_in),
      .PCPlusFour_in   (PCPlusFour_in),
      .we              (we),
      .waddr           (waddr),
      .wdata           (wdata)
   );

   // Reset wins over a write presented in the same cycle.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
         end
         write_count <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
         write_count <= write_count + 32'd1;
      end
   end

`ifdef WB_BYPASS_EN
   assign byp1 = we && Rst && (ReadReg1 == waddr);
   assign byp2 = we && Rst && (ReadReg2 == waddr);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   // $0 is hardwired; the stored entry is never written but is masked anyway.
   assign ReadData1 = (ReadReg1 == ADDR_W'(REG_ZERO)) ? '0 :
                      byp1 ? wdata : regs[ReadReg1];
   assign ReadData2 = (ReadReg2 == ADDR_W'(REG_ZERO)) ? '0 :
                      byp2 ? wdata : regs[ReadReg2];

   assign WriteCount = write_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array-based register model.
module tb_wb_regfile;

   logic        Clk;
   logic        Rst;
   logic        regWrite_in;
   logic        regWrite_jal_in;
   logic [4:0]  RegDst_in;
   logic [31:0] RegData_in;
   logic [31:0] PCPlusFour_in;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [31:0] WriteCount;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;

   wb_regfile dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .regWrite_in     (regWrite_in),
      .regWrite_jal_in (regWrite_jal_in),
      .RegDst_in       (RegDst_in),
      .RegData_in      (RegData_in),
      .PCPlusFour_in   (PCPlusFour_in),
      .ReadReg1        (ReadReg1),
      .ReadReg2        (ReadReg2),
      .ReadData1       (ReadData1),
      .ReadData2       (ReadData2),
      .WriteCount      (WriteCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_regs[29] = 32'h0000_03FC;
      m_cnt = 32'h0;
   endtask

   // Expected read value given the write presented this cycle.
   function automatic logic [31:0] exp_read(input logic [4:0] idx, input logic rst_n,
                                            input logic hit, input logic [4:0] wa,
                                            input logic [31:0] wd);
      if (idx == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
      if (rst_n && hit && idx == wa) return wd;
`endif
      return m_regs[idx];
   endfunction

   // Presents one cycle of inputs, checks reads/counter before the edge, then
   // advances the model across the edge.
   task automatic step(input string tag, input logic rst_n, input logic wr, input logic jal,
                       input logic [4:0] dst, input logic [31:0] data, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2);
      logic        hit;
      logic [4:0]  wa;
      logic [31:0] wd;
      Rst = rst_n; regWrite_in = wr; regWrite_jal_in = jal;
      RegDst_in = dst; RegData_in = data; PCPlusFour_in = pc;
      ReadReg1 = r1; ReadReg2 = r2;
      hit = jal | wr;
      wa  = jal ? 5'd31 : dst;
      wd  = jal ? pc : data;
      if (wa == 5'd0) hit = 1'b0;
      #1;
      check({tag, ".rd1"}, ReadData1, exp_read(r1, rst_n, hit, wa, wd));
      check({tag, ".rd2"}, ReadData2, exp_read(r2, rst_n, hit, wa, wd));
      check({tag, ".cnt"}, WriteCount, m_cnt);
      @(posedge Clk);
      if (!rst_n) model_reset();
      else if (hit) begin
         m_regs[wa] = wd;
         m_cnt      = m_cnt + 32'd1;
      end
      @(negedge Clk);
   endtask

   initial begin
      Rst = 1'b0; regWrite_in = 1'b0; regWrite_jal_in = 1'b0;
      RegDst_in = '0; RegData_in = '0; PCPlusFour_in = '0;
      ReadReg1 = '0; ReadReg2 = '0;
      repeat (2) @(posedge Clk);
      model_reset();
      @(negedge Clk);

      for (int i = 0; i < 32; i++)
         step("rst_scan", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
      check("sp_reset", ReadData1, 32'h0);
      ReadReg1 = 5'd29; #1;
      check("sp_value", ReadData1, 32'h0000_03FC);

      step("wr8",   1'b1, 1'b1, 1'b0, 5'd8, 32'hDEAD_BEEF, 32'h0, 5'd8, 5'd0);
      step("rd8",   1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd8);
      check("wr8_cnt", WriteCount, 32'd1);

      step("jal",   1'b1, 1'b1, 1'b1, 5'd5, 32'h1111_1111, 32'h0000_0044, 5'd5, 5'd31);
      step("jalrd", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd5);
      check("jal_ra", ReadData1, 32'h0000_0044);
      check("jal_r5", ReadData2, 32'h0);

      step("wr0",   1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
      step("rd0",   1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
      check("wr0_cnt", WriteCount, 32'd2);

      step("wr9a",  1'b1, 1'b1, 1'b0, 5'd9, 32'h5, 32'h0, 5'd0, 5'd0);
      step("wr9b",  1'b1, 1'b1, 1'b0, 5'd9, 32'h7, 32'h0, 5'd0, 5'd9);
      step("rd9",   1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);
      check("rd9_now", ReadData2, 32'h7);

      dut.write_count = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      step("wrap",  1'b1, 1'b1, 1'b0, 5'd4, 32'h1234, 32'h0, 5'd4, 5'd0);
      check("wrap_cnt", WriteCount, 32'h0);
      step("rstw",  1'b0, 1'b1, 1'b0, 5'd3, 32'hA, 32'h0, 5'd3, 5'd4);
      step("rstrd", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd29);
      check("rst_r3", ReadData1, 32'h0);
      check("rst_cnt", WriteCount, 32'h0);

      for (int n = 0; n < 400; n++) begin
         step("rand", ($urandom_range(0, 39) != 0), 1'($urandom), ($urandom_range(0, 5) == 0),
              5'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
